// File: rtl/mem_bist_init.sv
// Backplane bus-master memory self-test: writes a pattern over an address range,
// reads it back, and records the first miscompare or NXM timeout.
module mem_bist_init #(
  parameter int RDLAT   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic         clkT,
  input  logic         rst,
  input  logic         start,
  input  logic [16:35] cfgFIRST,
  input  logic [16:35] cfgLAST,
  input  logic [0:35]  cfgPAT,
  input  logic         cfgMODE,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic         nxm,
  output logic [16:35] errADDR,
  output logic [0:35]  errEXP,
  output logic [0:35]  errGOT,
  output logic         busREQO,
  input  logic         busACKI,
  output logic [0:35]  busADDRO,
  output logic [0:35]  busDATAO,
  input  logic [0:35]  busDATAI
);

  typedef enum logic [2:0] {IDLE, WREQ, RREQ, RWAIT, DONE} state_t;

  localparam logic [7:0] TMO_LIM  = 8'(TIMEOUT);
  localparam logic [1:0] LAT_LAST = 2'(RDLAT - 1);

  function automatic logic [0:35] pattern(input logic [0:35] pat, input logic mode,
                                          input logic [16:35] a);
    return mode ? (pat ^ {16'd0, a}) : pat;
  endfunction

  // Flag bits: 3 READ, 5 WRITE, 8 PHYS; address in the low 20 bits.
  function automatic logic [0:35] bus_word(input logic wr, input logic [16:35] a);
    logic [0:35] w;
    w        = 36'd0;
    w[3]     = ~wr;
    w[5]     = wr;
    w[8]     = 1'b1;
    w[16:35] = a;
    return w;
  endfunction

  state_t       state_q;
  logic [16:35] first_q, last_q, addr_q, err_addr_q;
  logic [0:35]  pat_q, err_exp_q, err_got_q, bus_addr_q, bus_data_q;
  logic         mode_q, busy_q, done_q, fail_q, nxm_q, req_q;
  logic [7:0]   tmo_q;
  logic [1:0]   lat_q;

  logic [16:35] addr_d;
  logic [0:35]  exp_d;

  assign addr_d = addr_q + 20'd1;
  assign exp_d  = pattern(pat_q, mode_q, addr_q);

  always_ff @(posedge clkT) begin
    if (rst) begin
      state_q    <= IDLE;
      first_q    <= 20'd0;
      last_q     <= 20'd0;
      addr_q     <= 20'd0;
      pat_q      <= 36'd0;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      nxm_q      <= 1'b0;
      err_addr_q <= 20'd0;
      err_exp_q  <= 36'd0;
      err_got_q  <= 36'd0;
      req_q      <= 1'b0;
      bus_addr_q <= 36'd0;
      bus_data_q <= 36'd0;
      tmo_q      <= 8'd0;
      lat_q      <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            first_q    <= cfgFIRST;
            last_q     <= cfgLAST;
            pat_q      <= cfgPAT;
            mode_q     <= cfgMODE;
            addr_q     <= cfgFIRST;
            fail_q     <= 1'b0;
            nxm_q      <= 1'b0;
            err_addr_q <= 20'd0;
            err_exp_q  <= 36'd0;
            err_got_q  <= 36'd0;
            tmo_q      <= 8'd0;
            lat_q      <= 2'd0;
            if (cfgFIRST > cfgLAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= WREQ;
              busy_q     <= 1'b1;
              req_q      <= 1'b1;
              bus_addr_q <= bus_word(1'b1, cfgFIRST);
              bus_data_q <= pattern(cfgPAT, cfgMODE, cfgFIRST);
            end
          end
        end
        WREQ: begin
          if (busACKI) begin
            tmo_q <= 8'd0;
            if (addr_q == last_q) begin
              addr_q     <= first_q;
              state_q    <= RREQ;
              bus_addr_q <= bus_word(1'b0, first_q);
              bus_data_q <= 36'd0;
            end else begin
              addr_q     <= addr_d;
              bus_addr_q <= bus_word(1'b1, addr_d);
              bus_data_q <= pattern(pat_q, mode_q, addr_d);
            end
          end else if (tmo_q == TMO_LIM) begin
            fail_q     <= 1'b1;
            nxm_q      <= 1'b1;
            err_addr_q <= addr_q;
            err_exp_q  <= exp_d;
            err_got_q  <= 36'd0;
            state_q    <= DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            bus_addr_q <= 36'd0;
            bus_data_q <= 36'd0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RREQ: begin
          if (busACKI) begin
            tmo_q      <= 8'd0;
            lat_q      <= 2'd0;
            req_q      <= 1'b0;
            bus_addr_q <= 36'd0;
            state_q    <= RWAIT;
          end else if (tmo_q == TMO_LIM) begin
            fail_q     <= 1'b1;
            nxm_q      <= 1'b1;
            err_addr_q <= addr_q;
            err_exp_q  <= exp_d;
            err_got_q  <= 36'd0;
            state_q    <= DONE;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            bus_addr_q <= 36'd0;
            bus_data_q <= 36'd0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        RWAIT: begin
          if (lat_q == LAT_LAST) begin
            if (busDATAI != exp_d) begin
              fail_q     <= 1'b1;
              err_addr_q <= addr_q;
              err_exp_q  <= exp_d;
              err_got_q  <= busDATAI;
              state_q    <= DONE;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
            end else if (addr_q == last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              addr_q     <= addr_d;
              state_q    <= RREQ;
              req_q      <= 1'b1;
              bus_addr_q <= bus_word(1'b0, addr_d);
            end
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign nxm      = nxm_q;
  assign errADDR  = err_addr_q;
  assign errEXP   = err_exp_q;
  assign errGOT   = err_got_q;
  assign busREQO  = req_q;
  assign busADDRO = bus_addr_q;
  assign busDATAO = bus_data_q;

endmodule

// File: tb/tb_mem_bist_init.sv
// Directed bench for mem_bist_init: a transaction/timeline model of the test run is
// checked against the bus and status outputs every cycle, plus literal end results.
module tb_mem_bist_init;

  localparam int          TMO     = 15;
  localparam logic [35:0] WFL     = 36'h0_4800_0000;
  localparam logic [35:0] RFL     = 36'h1_0800_0000;
  localparam logic [19:0] NXM_LIM = 20'o100000;

  logic        clkT = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [19:0] cfgFIRST = 20'd0, cfgLAST = 20'd0;
  logic [35:0] cfgPAT = 36'd0;
  logic        cfgMODE = 1'b0;
  logic        busy, done, fail, nxm, busREQO;
  logic        busACKI = 1'b0;
  logic [19:0] errADDR;
  logic [35:0] errEXP, errGOT, busADDRO, busDATAO;
  logic [35:0] busDATAI = 36'd0;

  mem_bist_init #(.RDLAT(1), .TIMEOUT(TMO)) dut (
    .clkT(clkT), .rst(rst), .start(start),
    .cfgFIRST(cfgFIRST), .cfgLAST(cfgLAST), .cfgPAT(cfgPAT), .cfgMODE(cfgMODE),
    .busy(busy), .done(done), .fail(fail), .nxm(nxm),
    .errADDR(errADDR), .errEXP(errEXP), .errGOT(errGOT),
    .busREQO(busREQO), .busACKI(busACKI), .busADDRO(busADDRO),
    .busDATAO(busDATAO), .busDATAI(busDATAI)
  );

  always #5 clkT = ~clkT;

  int cyc = 0;
  always @(posedge clkT) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  // Responder configuration and memory contents
  logic [35:0] mem [logic [19:0]];
  logic        nxm_en = 1'b0, corrupt_en = 1'b0;
  logic [19:0] corrupt_addr = 20'd0;

  // Expected run, derived from the start configuration
  logic [35:0] qa[$], qd[$];
  int          t0 = 0, stop_rel = 0, done_cyc = 0, nwords = 0, nxm_start = 0, done_rel = -1;
  logic        e_fail, e_nxm;
  logic [19:0] e_addr;
  logic [35:0] e_exp, e_got;

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [35:0] pat_of(input logic [35:0] p, input logic m, input logic [19:0] a);
    return m ? (p ^ {16'd0, a}) : p;
  endfunction

  function automatic logic is_nxm(input logic [19:0] a);
    return nxm_en && (a >= NXM_LIM);
  endfunction

  task automatic build_model(input logic [19:0] f, input logic [19:0] l,
                             input logic [35:0] p, input logic m);
    logic [19:0] a;
    qa.delete(); qd.delete();
    e_fail = 1'b0; e_nxm = 1'b0; e_addr = 20'd0; e_exp = 36'd0; e_got = 36'd0;
    nxm_start = 1 << 30;
    if (f > l) begin
      nwords = 0; done_cyc = 1;
      return;
    end
    nwords = int'(l - f) + 1;
    for (int i = 0; i < nwords; i++) begin
      a = f + 20'(i);
      qa.push_back(WFL | {16'd0, a}); qd.push_back(pat_of(p, m, a));
    end
    for (int i = 0; i < nwords; i++) begin
      a = f + 20'(i);
      qa.push_back(RFL | {16'd0, a}); qd.push_back(36'd0);
    end
    done_cyc = 3 * nwords + 1;
    for (int i = 0; i < nwords; i++) begin
      a = f + 20'(i);
      if (is_nxm(a)) begin
        e_fail = 1'b1; e_nxm = 1'b1; e_addr = a; e_exp = pat_of(p, m, a);
        nxm_start = 1 + i; done_cyc = nxm_start + TMO + 1;
        return;
      end
    end
    for (int j = 0; j < nwords; j++) begin
      a = f + 20'(j);
      if (is_nxm(a)) begin
        e_fail = 1'b1; e_nxm = 1'b1; e_addr = a; e_exp = pat_of(p, m, a);
        nxm_start = nwords + 1 + 2 * j; done_cyc = nxm_start + TMO + 1;
        return;
      end
      if (corrupt_en && a == corrupt_addr) begin
        e_fail = 1'b1; e_addr = a; e_exp = pat_of(p, m, a); e_got = e_exp ^ 36'd1;
        done_cyc = nwords + 3 + 2 * j;
        return;
      end
    end
  endtask

  // Memory responder: ACK decided 1 time unit after each edge, read data one cycle after ACK.
  initial begin
    logic        p_req, p_ack, rd_valid;
    logic [35:0] p_addr, p_data;
    logic [19:0] rd_addr;
    p_req = 1'b0; p_ack = 1'b0; p_addr = 36'd0; p_data = 36'd0;
    forever begin
      @(posedge clkT); #1;
      rd_valid = 1'b0; rd_addr = 20'd0;
      if (p_req && p_ack) begin
        if (p_addr[30]) mem[p_addr[19:0]] = p_data;
        rd_valid = p_addr[32]; rd_addr = p_addr[19:0];
      end
      if (rd_valid)
        busDATAI = (mem.exists(rd_addr) ? mem[rd_addr] : 36'd0) ^
                   ((corrupt_en && rd_addr == corrupt_addr) ? 36'd1 : 36'd0);
      else
        busDATAI = 36'd0;
      busACKI = busREQO && !is_nxm(busADDRO[19:0]);
      p_req = busREQO; p_ack = busACKI; p_addr = busADDRO; p_data = busDATAO;
    end
  end

  // Per-cycle comparison against the expected timeline and transaction list
  always @(negedge clkT) begin : cmp
    int   r;
    logic eb, ed, er;
    r = cyc - t0;
    if (r >= 1 && r <= stop_rel) begin
      eb = (r < done_cyc);
      ed = (r == done_cyc);
      er = eb && ((r <= nwords) || ((r - nwords - 1) % 2 == 0) || (r >= nxm_start));
      chk("busy", 36'(busy), 36'(eb));
      chk("done", 36'(done), 36'(ed));
      chk("busREQO", 36'(busREQO), 36'(er));
      if (done) done_rel = r;
      if (busREQO) begin
        if (qa.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_xfer: got request %h expected none", busADDRO);
        end else begin
          chk("busADDRO", busADDRO, qa[0]);
          chk("busDATAO", busDATAO, qd[0]);
          if (busACKI) begin
            void'(qa.pop_front());
            void'(qd.pop_front());
          end
        end
      end else begin
        chk("busDATAO_idle", busDATAO, 36'd0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 36'(busy), 36'd0);
    chk({tag, "_done"}, 36'(done), 36'd0);
    chk({tag, "_fail"}, 36'(fail), 36'd0);
    chk({tag, "_nxm"}, 36'(nxm), 36'd0);
    chk({tag, "_errADDR"}, 36'(errADDR), 36'd0);
    chk({tag, "_errEXP"}, errEXP, 36'd0);
    chk({tag, "_errGOT"}, errGOT, 36'd0);
    chk({tag, "_busREQO"}, 36'(busREQO), 36'd0);
    chk({tag, "_busADDRO"}, busADDRO, 36'd0);
    chk({tag, "_busDATAO"}, busDATAO, 36'd0);
  endtask

  // ign_at: 0 none, -1 at the done cycle, else cycle of an extra start pulse.
  task automatic run_test(input logic [19:0] f, input logic [19:0] l, input logic [35:0] p,
                          input logic m, input int ign_at, input int rst_at);
    int r, end_rel, ign;
    @(posedge clkT); #2;
    build_model(f, l, p, m);
    mem.delete();
    ign      = (ign_at < 0) ? done_cyc : ign_at;
    stop_rel = (rst_at > 0) ? rst_at : done_cyc + 1;
    end_rel  = (rst_at > 0) ? rst_at + 1 : done_cyc + 1;
    done_rel = -1;
    t0       = cyc;
    cfgFIRST = f; cfgLAST = l; cfgPAT = p; cfgMODE = m; start = 1'b1;
    r = 0;
    while (r < end_rel) begin
      @(negedge clkT);
      r = cyc - t0;
      if (r == 1 || (ign > 0 && r == ign + 1)) start = 1'b0;
      if (ign > 0 && r == ign) begin
        start = 1'b1; cfgFIRST = 20'd3; cfgLAST = 20'hFFFFF; cfgPAT = ~p; cfgMODE = ~m;
      end
      if (rst_at > 0 && r == rst_at) rst = 1'b1;
    end
    if (rst_at > 0) begin
      chk_zero("rst_mid");
      rst = 1'b0;
    end else begin
      chk("fail", 36'(fail), 36'(e_fail));
      chk("nxm", 36'(nxm), 36'(e_nxm));
      chk("errADDR", 36'(errADDR), 36'(e_addr));
      chk("errEXP", errEXP, e_exp);
      chk("errGOT", errGOT, e_got);
      if (!e_fail) chk("xfers_left", 36'(qa.size()), 36'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clkT);
    chk_zero("reset");
    rst = 1'b0;

    run_test(20'd0, 20'd7, 36'o123456701234, 1'b0, 0, 0);
    chk("t1_done_cycle", 36'(done_rel), 36'd25);
    chk("t1_fail", 36'(fail), 36'd0);

    run_test(20'd0, 20'd7, 36'o123456701234, 1'b0, 0, 13);

    run_test(20'd0, 20'd7, 36'o555555555555, 1'b1, 5, 0);
    chk("t3_done_cycle", 36'(done_rel), 36'd25);

    corrupt_en = 1'b1; corrupt_addr = 20'o376010;
    run_test(20'o376000, 20'o376037, 36'o707070707070, 1'b1, 0, 0);
    chk("t4_fail", 36'(fail), 36'd1);
    chk("t4_errADDR", 36'(errADDR), 36'o376010);
    chk("t4_errEXP", errEXP, 36'o707070707070 ^ 36'o376010);
    chk("t4_errGOT", errGOT, 36'o707070707070 ^ 36'o376010 ^ 36'd1);
    chk("t4_word376005", mem[20'o376005], 36'o707070707070 ^ 36'o376005);
    chk("t4_done_cycle", 36'(done_rel), 36'd51);
    corrupt_en = 1'b0;

    nxm_en = 1'b1;
    run_test(20'o77776, 20'o100001, 36'o777000777000, 1'b0, 0, 0);
    chk("t5_nxm", 36'(nxm), 36'd1);
    chk("t5_errADDR", 36'(errADDR), 36'o100000);
    chk("t5_done_cycle", 36'(done_rel), 36'd19);
    nxm_en = 1'b0;

    run_test(20'd5, 20'd4, 36'o111111111111, 1'b0, 0, 0);
    chk("t6_done_cycle", 36'(done_rel), 36'd1);

    run_test(20'hFFFFF, 20'hFFFFF, 36'o246024602460, 1'b1, 0, 0);
    chk("t7_done_cycle", 36'(done_rel), 36'd4);
    chk("t7_writes", 36'(mem.num()), 36'd1);

    run_test(20'd10, 20'd12, 36'o000777000777, 1'b1, -1, 0);
    chk("t8_done_cycle", 36'(done_rel), 36'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bist_init.md
# mem_bist_init

Bus-initiator memory self-test engine for the KS-10 backplane. Once started, it writes a pattern over a physical memory address range. It then reads every word back, compares it, and reports the first miscompare or non-existent-memory (NXM) timeout. It connects to the backplane as a bus master, the opposite end of the memory controller's request/acknowledge slave interface, and is driven by console configuration registers.

## Interface
- RDLAT, 1, cycles from the read ACK cycle to the cycle in which busDATAI holds valid read data (1..3)
- TIMEOUT, 15, maximum cycles busREQO may stay high without busACKI before NXM is declared (1..255)

- clkT  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle pulse that begins a test; ignored while busy=1
- cfgFIRST  in  [16:35]  first memory address, inclusive
- cfgLAST  in  [16:35]  last memory address, inclusive
- cfgPAT  in  [0:35]  pattern word
- cfgMODE  in  1  0: data=cfgPAT; 1: data=cfgPAT XOR {16'b0,addr[16:35]}
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at test end
- fail  out  1  sticky; last test miscompared or hit NXM; cleared by start
- nxm  out  1  sticky; last failure was a timeout; cleared by start
- errADDR  out  [16:35]  failing address
- errEXP  out  [0:35]  expected data at the failing address
- errGOT  out  [0:35]  data read at the failing address (0 on NXM)
- busREQO  out  1  bus request
- busACKI  in  1  bus acknowledge from the responder
- busADDRO  out  [0:35]  flags [0:13] and address; bit 3 READ, bit 5 WRITE, bit 8 PHYS, other flag bits 0; [14:15]=0; [16:35]=addr
- busDATAO  out  [0:35]  write data; 0 when not writing
- busDATAI  in  [0:35]  read data

## Operation
- All outputs are registered. Reset value of every output is 0. The state machine resets to IDLE.
- States: IDLE, WREQ, RREQ, RWAIT, DONE.
- IDLE: on start, clear fail, nxm and the err* outputs, and set addr=cfgFIRST.
  - If cfgFIRST > cfgLAST (unsigned), go to DONE with no bus traffic.
  - Otherwise set busy and go to WREQ.
- WREQ: drive busREQO=1, the WRITE and PHYS flags, addr, and busDATAO=pattern(addr).
  - On busACKI: if addr==cfgLAST, set addr=cfgFIRST and go to RREQ; otherwise addr+1 and stay in WREQ.
- RREQ: drive busREQO=1 with the READ and PHYS flags and addr. On busACKI, drop busREQO and go to RWAIT.
- RWAIT: count RDLAT cycles, then sample busDATAI and compare it against pattern(addr).
  - On mismatch: set fail, load errADDR/errEXP/errGOT, and go to DONE.
  - On match: if addr==cfgLAST, go to DONE; otherwise addr+1 and go to RREQ.
- DONE: one cycle with done=1, busy=0, and bus outputs 0, then IDLE.
- End of range is detected by equality with cfgLAST, never by counter overflow. cfgLAST=20'hFFFFF is legal, and the address counter never wraps inside a test.
- Timeout: a counter increments each cycle busREQO=1 and busACKI=0, and clears on ACK.
  - When it reaches TIMEOUT: set fail, set nxm, errADDR=addr, errEXP=pattern(addr) (write or read phase), errGOT=0, drop busREQO, and go to DONE.
- cfg* inputs are sampled only at start. Changing them mid-test has no effect.
- rst mid-test: at the next edge busREQO=0 and all outputs are 0. No partial-state recovery.

## Timing
- Start accepted at edge 0: busREQO=1 and busy=1 from cycle 1.
- Write throughput: one word per cycle when busACKI is held high. Address and data advance on the edge that samples ACK.
- Read: ACK sampled in cycle n. busREQO=0 in cycles n+1..n+RDLAT. busDATAI is sampled at the end of cycle n+RDLAT. The next read request is asserted in cycle n+RDLAT+1.
- For a test with no miscompare and N=cfgLAST-cfgFIRST+1, always-ACK, RDLAT=1: done pulses at cycle 1+N+2N, i.e. 3N+1.
- NXM: busREQO falls and done pulses TIMEOUT+1 cycles after the unacknowledged request first asserts.
- start coincident with done is ignored. start in the IDLE cycle immediately after DONE is accepted.

## Test plan
- FIRST=0, LAST=7, PAT=36'o123456701234, MODE=0, always-ACK memory model, RDLAT=1 -> 8 writes then 8 reads; done at cycle 25; fail=0.
- MODE=1, FIRST=20'o376000, LAST=20'o376037 -> the word at 376005 reads PAT^376005; the model corrupts bit 35 at 376010 -> fail=1, errADDR=376010, errGOT=errEXP^1.
- Model never ACKs addresses >= 20'o100000; FIRST=20'o77776, LAST=20'o100001 -> nxm=1, errADDR=20'o100000 during the write phase; busREQO low within TIMEOUT+1 cycles.
- FIRST=5, LAST=4 -> done one cycle after start; busREQO never asserted; fail=0.
- FIRST=LAST=20'hFFFFF -> exactly one write and one read; no address wrap; done; fail=0.
- Assert rst in the third read cycle -> all outputs 0 after the edge; a new start runs cleanly; a start pulse while busy=1 changes nothing.
